// File: rtl/my9262_chain_drv.sv
// Serialising driver for a daisy chain of MY9262 LED drivers: stream words in, Di/Dclk/Lat/Gck out.
// Optional command frames are enabled by defining MY9262_CMD_EN.
module my9262_chain_drv #(
  parameter int N_CHIPS     = 4,
  parameter int CH_PER_CHIP = 16,
  parameter int GS_BITS     = 16,
  parameter int DCLK_DIV    = 4,
  parameter int LAT_CYCLES  = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int GCK_DIV     = 2
) (
  input  logic               CLK_60M,
  input  logic               RST,
  input  logic               start,
  input  logic [GS_BITS-1:0] pix_data,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic               gck_en,
  output logic               busy,
  output logic               frame_done,
  output logic               my9262_Di,
  output logic               my9262_Dclk,
  output logic               my9262_Lat,
  output logic               my9262_Gck
`ifdef MY9262_CMD_EN
  ,
  input  logic               cmd_start,
  input  logic [15:0]        cmd_word
`endif
);

  localparam logic [15:0] CELL_LAST      = 16'(DCLK_DIV - 1);
  localparam logic [15:0] CLK_HI         = 16'(DCLK_DIV / 2);
  localparam logic [15:0] GAP_LAST       = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] PIX_WORDS_LAST = 16'(N_CHIPS * CH_PER_CHIP - 1);
  localparam logic [15:0] CMD_WORDS_LAST = 16'(N_CHIPS - 1);
  localparam logic [15:0] PIX_LAT_LAST   = 16'(LAT_CYCLES - 1);
  localparam logic [15:0] CMD_LAT_LAST   = 16'(2 * LAT_CYCLES - 1);
  localparam logic [15:0] GCK_HALF_LAST  = 16'(GCK_DIV / 2 - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, LATCH, DONE} state_t;
  state_t state, next_state;

  logic [15:0] cnt, word_cnt, gck_ph;
  logic [3:0]  bit_cnt;
  logic [14:0] sr;
  logic        di_r, gck_r;
  logic [15:0] pix_ext, ld_word, words_last, lat_last;
  logic        cmd_mode, go, hs, cell_end, word_end, last_word;

  assign pix_ext = 16'(pix_data);

`ifdef MY9262_CMD_EN
  logic [15:0] cmd_q;
  assign go = start | cmd_start;
  // cmd_start has priority over start when both arrive in IDLE.
  always_ff @(posedge CLK_60M) begin
    if (RST) begin
      cmd_mode <= 1'b0;
      cmd_q    <= '0;
    end else if (state == IDLE) begin
      cmd_mode <= cmd_start;
      cmd_q    <= cmd_word;
    end
  end
  assign ld_word = cmd_mode ? cmd_q : pix_ext;
`else
  assign cmd_mode = 1'b0;
  assign go       = start;
  assign ld_word  = pix_ext;
`endif

  assign words_last = cmd_mode ? CMD_WORDS_LAST : PIX_WORDS_LAST;
  assign lat_last   = cmd_mode ? CMD_LAT_LAST : PIX_LAT_LAST;

  // Stream handshake: a word transfers on any cycle where pix_valid and pix_ready are
  // both high; pix_ready is only high in LOAD and pix_valid may stay low indefinitely.
  assign hs        = (state == LOAD) && (cmd_mode || pix_valid);
  assign cell_end  = (state == SHIFT) && (cnt == CELL_LAST);
  assign word_end  = cell_end && (bit_cnt == 4'd15);
  assign last_word = (word_cnt == words_last);

  always_ff @(posedge CLK_60M) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    pix_ready   = 1'b0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    my9262_Dclk = 1'b0;
    my9262_Lat  = 1'b0;
    case (state)
      IDLE: if (go) next_state = LOAD;
      LOAD: begin
        busy      = 1'b1;
        pix_ready = !cmd_mode;
        if (hs) next_state = SHIFT;
      end
      SHIFT: begin
        busy        = 1'b1;
        my9262_Dclk = (cnt >= CLK_HI);
        if (word_end) next_state = last_word ? GAP : LOAD;
      end
      GAP: begin
        busy = 1'b1;
        if (cnt == GAP_LAST) next_state = LATCH;
      end
      LATCH: begin
        busy       = 1'b1;
        my9262_Lat = 1'b1;
        if (cnt == lat_last) next_state = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Di is registered so it holds its last bit through LOAD stalls and the gap.
  always_ff @(posedge CLK_60M) begin
    if (RST) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      sr       <= '0;
      di_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt      <= '0;
          bit_cnt  <= '0;
          word_cnt <= '0;
        end
        LOAD: if (hs) begin
          sr      <= ld_word[14:0];
          di_r    <= ld_word[15];
          cnt     <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (cell_end) begin
            cnt <= '0;
            if (bit_cnt == 4'd15) begin
              word_cnt <= word_cnt + 16'd1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              di_r    <= sr[14];
              sr      <= {sr[13:0], 1'b0};
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt  <= '0;
            di_r <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        LATCH: cnt <= cnt + 16'd1;
        default: ;
      endcase
    end
  end

  // Gck parks low: a disabled clock always finishes its high half before stopping.
  always_ff @(posedge CLK_60M) begin
    if (RST) begin
      gck_ph <= '0;
      gck_r  <= 1'b0;
    end else if (!gck_r && !gck_en) begin
      gck_ph <= '0;
    end else if (gck_ph == GCK_HALF_LAST) begin
      gck_ph <= '0;
      gck_r  <= ~gck_r;
    end else begin
      gck_ph <= gck_ph + 16'd1;
    end
  end

  assign my9262_Di  = di_r;
  assign my9262_Gck = gck_r;

endmodule

// File: tb/tb_my9262_chain_drv.sv
// Directed bench for my9262_chain_drv: frame timing, stall, mid-frame reset, stray start, Gck gating.
module tb_my9262_chain_drv;
  localparam int N_CHIPS = 2;
  localparam int CH      = 16;
  localparam int DDIV    = 4;
  localparam int LATC    = 8;
  localparam int GAPC    = 4;
  localparam int GDIV    = 2;
  localparam int W       = N_CHIPS * CH;
  localparam int FRAME   = 1 + W * (1 + 16 * DDIV) + GAPC + LATC;

  // clock / reset
  logic clk = 1'b0;
  logic rst, start, pix_valid, gck_en;
  logic [15:0] pix_data;
  logic pix_ready, busy, frame_done, di, dclk, lat, gck;
  always #5 clk = ~clk;

`ifdef MY9262_CMD_EN
  logic cmd_start = 1'b0;
  logic [15:0] cmd_word = 16'h0;
`endif

  my9262_chain_drv #(
    .N_CHIPS(N_CHIPS), .CH_PER_CHIP(CH), .GS_BITS(16), .DCLK_DIV(DDIV),
    .LAT_CYCLES(LATC), .GAP_CYCLES(GAPC), .GCK_DIV(GDIV)
  ) dut (
    .CLK_60M(clk), .RST(rst), .start(start), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .gck_en(gck_en), .busy(busy),
    .frame_done(frame_done), .my9262_Di(di), .my9262_Dclk(dclk),
    .my9262_Lat(lat), .my9262_Gck(gck)
`ifdef MY9262_CMD_EN
    , .cmd_start(cmd_start), .cmd_word(cmd_word)
`endif
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // monitor: rebuild words from Di at Dclk rises, measure gap and Lat width
  logic prev_dclk = 1'b0, prev_lat = 1'b0;
  logic [15:0] sh = 16'h0;
  logic [31:0] exp_w;
  int nbits = 0, rises = 0, lat_w = 0, last_lat_w = 0, low_run = 0;
  int gap_at_lat = 0, di_in_lat = 0, done_cnt = 0, ready_cnt = 0;

  always @(negedge clk) begin
    if (!busy) nbits = 0;
    if (dclk && !prev_dclk) begin
      sh = {sh[14:0], di};
      nbits++;
      rises++;
      if (nbits == 16) begin
        nbits = 0;
        if (exp_q.size() != 0) exp_w = 32'(exp_q.pop_front());
        else                   exp_w = 32'hDEAD_BEEF;
        check("word", 32'(sh), exp_w);
      end
    end
    if (lat) begin
      if (!prev_lat) begin
        lat_w      = 0;
        gap_at_lat = low_run;
        di_in_lat  = 0;
      end
      lat_w++;
      if (di) di_in_lat++;
    end else if (prev_lat) begin
      last_lat_w = lat_w;
    end
    if (dclk) low_run = 0;
    else      low_run++;
    if (frame_done) done_cnt++;
    if (pix_ready)  ready_cnt++;
    prev_dclk = dclk;
    prev_lat  = lat;
  end

  // driver: one grayscale frame, with optional stall, abort-by-reset and stray start pulses
  task automatic run_frame(input logic [15:0] base, input int stall_word, input int stall_len,
                           input int abort_word, input bit extra_start, input string tag);
    int n, idx, stalled, since_hs, r0, d0, exp_len;
    bit done;
    logic [15:0] pw;
    r0 = rises; d0 = done_cnt; idx = 0; stalled = 0; since_hs = 0; done = 0;
    exp_len = FRAME + stall_len;
    @(negedge clk);
    start = 1'b1; pix_data = base; pix_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({tag, "_busy_rise"}, 32'(busy), 1);
    while (!done && n <= exp_len + 50) begin
      if (frame_done) begin
        done = 1;
      end else begin
        if (abort_word >= 0 && idx == abort_word + 1 && since_hs == 22) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check({tag, "_outs_zero"}, {25'd0, pix_ready, busy, frame_done, di, dclk, lat, gck}, 0);
          check({tag, "_busy_zero"}, 32'(busy), 0);
          return;
        end
        start = extra_start && (n == 100 || n == FRAME - 1);
        if (pix_ready && idx == stall_word && stalled < stall_len) begin
          pix_valid = 1'b0;
          stalled++;
          pw = base + 16'(idx - 1);
          check({tag, "_stall_dclk"}, 32'(dclk), 0);
          check({tag, "_stall_di"}, 32'(di), 32'(pw[0]));
        end else begin
          pix_valid = 1'b1;
        end
        pix_data = base + 16'(idx);
        if (pix_ready && pix_valid) begin
          exp_q.push_back(pix_data);
          idx++;
          since_hs = 0;
        end else begin
          since_hs++;
        end
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(done), 1);
    check({tag, "_len"}, n, exp_len);
    check({tag, "_busy_fall"}, 32'(busy), 0);
    #1;
    check({tag, "_rises"}, rises - r0, 16 * W);
    check({tag, "_lat_width"}, last_lat_w, LATC);
    check({tag, "_gap"}, gap_at_lat, GAPC);
    check({tag, "_di_in_lat"}, di_in_lat, 0);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    repeat (10) @(negedge clk);
    check({tag, "_one_done"}, done_cnt - d0, 1);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 16'h0; gck_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {25'd0, pix_ready, busy, frame_done, di, dclk, lat, gck}, 0);
    rst = 1'b0;

    run_frame(16'h0000, -1, 0, -1, 1'b0, "f_basic");
    run_frame(16'h1235, 5, 10, -1, 1'b0, "f_stall");
    run_frame(16'hFFF0, -1, 0, 3, 1'b0, "f_abort");
    exp_q.delete();
    run_frame(16'h0A50, -1, 0, -1, 1'b0, "f_restart");
    run_frame(16'h8421, -1, 0, -1, 1'b1, "f_extra_start");
    pix_valid = 1'b0;

    // Gck gating
    @(negedge clk);
    check("gck_parked_init", 32'(gck), 0);
    gck_en = 1'b1;
    @(negedge clk);
    check("gck_first_rise", 32'(gck), 1);
    gck_en = 1'b0;
    @(negedge clk);
    check("gck_fall", 32'(gck), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("gck_parked", 32'(gck), 0);
    end
    gck_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("gck_toggle", 32'(gck), 32'(i % 2 == 0));
    end
    gck_en = 1'b0;
    repeat (3) @(negedge clk);

`ifdef MY9262_CMD_EN
    begin : cmd_test
      int n, r0, q0;
      bit done;
      r0 = rises; q0 = ready_cnt; done = 0;
      for (int i = 0; i < N_CHIPS; i++) exp_q.push_back(16'hA5C3);
      @(negedge clk);
      cmd_word = 16'hA5C3; cmd_start = 1'b1; start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0; start = 1'b0; cmd_word = 16'h0;
      n = 1;
      while (!done && n < 1000) begin
        if (frame_done) done = 1;
        else begin
          @(negedge clk);
          n++;
        end
      end
      check("cmd_len", n, 1 + N_CHIPS * (1 + 16 * DDIV) + GAPC + 2 * LATC);
      #1;
      check("cmd_lat_width", last_lat_w, 2 * LATC);
      check("cmd_no_ready", ready_cnt - q0, 0);
      check("cmd_rises", rises - r0, 16 * N_CHIPS);
      check("cmd_q_empty", exp_q.size(), 0);
      repeat (5) @(negedge clk);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
